// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and helpers for the IF->ID fetch packet queue
package if_id_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // One fetch packet as it crosses the IF->ID boundary
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [ILEN-1:0] inst;
    } fetch_pkt_t;

    // Occupancy counter must represent 0..depth inclusive
    function automatic int clog2_cnt(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_pkt_fifo.sv
// rtl/fetch_pkt_fifo.sv - generic first-word-fall-through storage with pointers, count and flags
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   i_push, i_pop      enqueue / dequeue requests (ignored when full / empty)
//   i_flush            synchronous discard of all entries, beats push and pop
//   i_data             entry written on push
//   o_data             entry at the head (raw storage, not masked)
//   o_count            occupancy 0..DEPTH
//   o_empty, o_full    occupancy flags
module fetch_pkt_fifo
    import if_id_pkg::*;
#(
    parameter int WIDTH = 160,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic                          i_flush,
    input  logic [WIDTH-1:0]              i_data,
    output logic [WIDTH-1:0]              o_data,
    output logic [clog2_cnt(DEPTH)-1:0]   o_count,
    output logic                          o_empty,
    output logic                          o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = clog2_cnt(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Flush cancels any same-cycle transfer so nothing is written or consumed
    assign w_do_push = i_push & ~o_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + CW'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; head data is masked by the wrapper when empty
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        r_count <= CW'(DEPTH));

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF->ID boundary: DEPTH-entry FWFT queue of {pc, pc4, inst} with flush
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   flush                       discard all queued packets at the next edge
//   f_valid/f_ready             fetch-side handshake, f_pc/f_pc4/f_inst packet
//   d_valid/d_ready             decode-side handshake, d_pc/d_pc4/d_inst head packet (zero when empty)
//   count, empty, full          occupancy and flags
//   almost_full                 count >= AFULL_LEVEL
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int INST_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          f_valid,
    output logic                          f_ready,
    input  logic [ADDR_WIDTH-1:0]         f_pc,
    input  logic [ADDR_WIDTH-1:0]         f_pc4,
    input  logic [INST_WIDTH-1:0]         f_inst,
    output logic                          d_valid,
    input  logic                          d_ready,
    output logic [ADDR_WIDTH-1:0]         d_pc,
    output logic [ADDR_WIDTH-1:0]         d_pc4,
    output logic [INST_WIDTH-1:0]         d_inst,
    output logic [clog2_cnt(DEPTH)-1:0]   count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full
);

    localparam int CW = clog2_cnt(DEPTH);
    localparam int PKT_W = 2 * ADDR_WIDTH + INST_WIDTH;
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count;
    logic [PKT_W-1:0] w_head;

    // Both ready/valid come from registered occupancy only, so no d_ready->f_ready path
    assign f_ready = ~w_full;
    assign d_valid = ~w_empty;
    assign w_push  = f_valid & f_ready;
    assign w_pop   = d_valid & d_ready;

    fetch_pkt_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  ({f_pc, f_pc4, f_inst}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Unwritten storage must never leak to decode
    assign {d_pc, d_pc4, d_inst} = d_valid ? w_head : '0;

    assign count       = w_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (w_count >= AFULL_CNT);

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue-based model
module tb_if_id_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [31:0] inst;
    } pkt_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          f_valid = 1'b0;
    logic          f_ready;
    logic [63:0]   f_pc = '0;
    logic [63:0]   f_pc4 = '0;
    logic [31:0]   f_inst = '0;
    logic          d_valid;
    logic          d_ready = 1'b0;
    logic [63:0]   d_pc;
    logic [63:0]   d_pc4;
    logic [31:0]   d_inst;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;

    int n_checks = 0;
    int n_errors = 0;
    pkt_t mq[$];

    if_id_queue #(.ADDR_WIDTH(64), .INST_WIDTH(32), .DEPTH(DEPTH), .AFULL_LEVEL(DEPTH-1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_pc4(f_pc4), .f_inst(f_inst),
        .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc), .d_pc4(d_pc4), .d_inst(d_inst),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    // Model: a packet is taken when fetch offers it and fewer than DEPTH are held;
    // head leaves when decode is ready and something is held; flush/reset drop everything.
    task automatic tick();
        bit   p, q, fl;
        pkt_t n;
        fl = flush;
        p  = f_valid && (mq.size() < DEPTH);
        q  = d_ready && (mq.size() > 0);
        n.pc = f_pc; n.pc4 = f_pc4; n.inst = f_inst;
        @(posedge clk);
        if (!reset || fl) begin
            mq.delete();
        end else begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(n);
        end
        @(negedge clk);
    endtask

    task automatic set_pkt(input logic [63:0] pc);
        f_pc = pc;
        f_pc4 = pc + 64'd4;
        f_inst = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0; f_valid = 1'b1; set_pkt(64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (d_valid !== 1'b0 || count !== '0 || f_ready !== 1'b1 || d_pc !== 64'h0) begin
                n_errors++;
                $display("FAIL reset_state got v=%b cnt=%0d rdy=%b pc=%h exp v=0 cnt=0 rdy=1 pc=0",
                         d_valid, count, f_ready, d_pc);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags got e=%b f=%b af=%b exp 1 0 0", empty, full, almost_full);
        end
        reset = 1'b1;
        f_pc = 64'h1000; f_pc4 = 64'h1004; f_inst = 32'h00000013;
        tick();
        f_valid = 1'b0;
        n_checks++;
        if (d_valid !== 1'b1 || d_pc !== 64'h1000 || d_pc4 !== 64'h1004 ||
            d_inst !== 32'h00000013 || count !== CW'(1)) begin
            n_errors++;
            $display("FAIL first_push got v=%b pc=%h pc4=%h inst=%h cnt=%0d exp 1 1000 1004 00000013 1",
                     d_valid, d_pc, d_pc4, d_inst, count);
        end
        d_ready = 1'b1; tick(); d_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [63:0] exp_seq [5];
        int k;
        d_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_valid = 1'b1; set_pkt(64'(4 * i));
            tick();
            n_checks++;
            if (count !== CW'(i + 1) || almost_full !== (i + 1 >= 3) ||
                full !== (i + 1 == 4) || f_ready !== (i + 1 < 4)) begin
                n_errors++;
                $display("FAIL fill_%0d got cnt=%0d af=%b full=%b rdy=%b", i, count, almost_full, full, f_ready);
            end
        end
        set_pkt(64'h10);
        tick(); tick();
        n_checks++;
        if (count !== CW'(4) || d_pc !== 64'h0 || f_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL full_hold got cnt=%0d pc=%h rdy=%b exp 4 0 0", count, d_pc, f_ready);
        end
        for (int i = 0; i < 5; i++) exp_seq[i] = 64'(4 * i);
        k = 0;
        d_ready = 1'b1;
        for (int c = 0; c < 20 && k < 5; c++) begin
            if (d_valid) begin
                n_checks++;
                if (d_pc !== exp_seq[k] || d_pc4 !== exp_seq[k] + 64'd4) begin
                    n_errors++;
                    $display("FAIL drain_order got pc=%h pc4=%h exp %h", d_pc, d_pc4, exp_seq[k]);
                end
                k++;
            end
            if (f_valid && f_ready) begin
                tick(); f_valid = 1'b0;
            end else begin
                tick();
            end
        end
        d_ready = 1'b0;
        n_checks++;
        if (k !== 5 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_count got %0d empty=%b exp 5 1", k, empty);
        end
    endtask

    task automatic test_concurrent();
        d_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            f_valid = 1'b1; set_pkt(64'h3000 + 64'(4 * i));
            tick();
            n_checks++;
            if (count !== CW'(1) || d_pc !== 64'h3000 + 64'(4 * i)) begin
                n_errors++;
                $display("FAIL stream_%0d got cnt=%0d pc=%h exp 1 %h", i, count, d_pc, 64'h3000 + 64'(4 * i));
            end
        end
        f_valid = 1'b0;
        tick();
        d_ready = 1'b0;
        n_checks++;
        if (count !== '0 || d_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_end got cnt=%0d v=%b exp 0 0", count, d_valid);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            f_valid = 1'b1; set_pkt(64'h500 + 64'(4 * i)); tick();
        end
        flush = 1'b1; f_valid = 1'b1; d_ready = 1'b1; set_pkt(64'h600);
        n_checks++;
        if (count !== CW'(3) || f_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_pre got cnt=%0d rdy=%b exp 3 1", count, f_ready);
        end
        tick();
        flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        n_checks++;
        if (count !== '0 || d_valid !== 1'b0 || empty !== 1'b1 || d_pc !== 64'h0 || f_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL flush_post got cnt=%0d v=%b e=%b pc=%h rdy=%b", count, d_valid, empty, d_pc, f_ready);
        end
        f_valid = 1'b1; set_pkt(64'h2000); tick(); f_valid = 1'b0;
        n_checks++;
        if (count !== CW'(1) || d_pc !== 64'h2000) begin
            n_errors++;
            $display("FAIL flush_repush got cnt=%0d pc=%h exp 1 2000", count, d_pc);
        end
        d_ready = 1'b1; tick(); d_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            f_valid = 1'b1; set_pkt(64'h700 + 64'(4 * i)); tick();
        end
        f_valid = 1'b0;
        n_checks++;
        if (count !== CW'(2)) begin
            n_errors++;
            $display("FAIL areset_pre got cnt=%0d exp 2", count);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (d_valid !== 1'b0 || count !== '0 || d_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL areset_immediate got v=%b cnt=%0d pc=%h exp 0 0 0", d_valid, count, d_pc);
        end
        #1;
        reset = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_random();
        bit            hold;
        bit            stall;
        logic [159:0]  prev_bus;
        logic [159:0]  exp_bus;
        hold = 1'b0; stall = 1'b0; prev_bus = '0;
        for (int c = 0; c < 10000; c++) begin
            exp_bus = (mq.size() != 0) ? {mq[0].pc, mq[0].pc4, mq[0].inst} : '0;
            n_checks++;
            if ({d_pc, d_pc4, d_inst} !== exp_bus || d_valid !== (mq.size() != 0)) begin
                n_errors++;
                $display("FAIL rand_head c=%0d got v=%b %h exp %h", c, d_valid, {d_pc, d_pc4, d_inst}, exp_bus);
            end
            n_checks++;
            if (count !== CW'(mq.size()) || f_ready !== (mq.size() < DEPTH) || empty !== (mq.size() == 0) ||
                full !== (mq.size() == DEPTH) || almost_full !== (mq.size() >= DEPTH - 1)) begin
                n_errors++;
                $display("FAIL rand_flags c=%0d got cnt=%0d rdy=%b e=%b f=%b af=%b exp cnt=%0d",
                         c, count, f_ready, empty, full, almost_full, mq.size());
            end
            if (stall) begin
                n_checks++;
                if ({d_pc, d_pc4, d_inst} !== prev_bus) begin
                    n_errors++;
                    $display("FAIL rand_stall c=%0d got %h exp %h", c, {d_pc, d_pc4, d_inst}, prev_bus);
                end
            end
            if (!hold) begin
                f_valid = ($urandom_range(0, 9) < 7);
                set_pkt({$urandom, $urandom & 32'hFFFF_FFFC});
            end
            d_ready = ($urandom_range(0, 9) < 6);
            flush   = ($urandom_range(0, 49) == 0);
            hold     = f_valid && !f_ready && !flush;
            stall    = d_valid && !d_ready && !flush;
            prev_bus = {d_pc, d_pc4, d_inst};
            tick();
        end
        f_valid = 1'b0; d_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fill();
        test_concurrent();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF→ID pipeline boundary. Replaces the single-stage IF/ID register and the fixed instruction buffer with one DEPTH-entry first-word-fall-through queue of fetch packets {pc, pc4, inst}.
- Uses valid/ready handshakes on both sides, plus flush for branch/exception redirect.
- Sits between the fetch unit and the decoder. Decouples fetch bursts from decode stalls.

Parameters:
- ADDR_WIDTH, 64, width of pc and pc4.
- INST_WIDTH, 32, instruction width.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all queued packets.
- f_valid  in  1  fetch presents a packet.
- f_ready  out  1  queue can accept a packet.
- f_pc  in  ADDR_WIDTH  fetch PC.
- f_pc4  in  ADDR_WIDTH  fetch PC+4.
- f_inst  in  INST_WIDTH  fetched instruction.
- d_valid  out  1  head packet valid to decode.
- d_ready  in  1  decode consumes head this cycle.
- d_pc  out  ADDR_WIDTH  head PC.
- d_pc4  out  ADDR_WIDTH  head PC+4.
- d_inst  out  INST_WIDTH  head instruction.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LEVEL.

Behaviour:
- Reset (reset low, asynchronous):
  - rd_ptr, wr_ptr and count = 0.
  - empty = 1; full = 0; almost_full = 0 (AFULL_LEVEL >= 1).
  - d_valid = 0; d_pc/d_pc4/d_inst = 0; f_ready = 1.
  - Storage array is not reset.
- Handshakes:
  - push = f_valid & f_ready.
  - pop = d_valid & d_ready.
  - f_ready = ~full. It is registered-state derived only, with no combinational path from d_ready.
  - d_valid = ~empty.
- Outputs are head-of-queue (FWFT). d_pc/d_pc4/d_inst = entry[rd_ptr] when d_valid, else all-zero.
- Latency: packet pushed at edge N is visible on d_* with d_valid = 1 after edge N; one cycle fetch→decode when empty.
- Hold:
  - While d_valid & ~d_ready, d_* remain stable.
  - The fetch side must hold f_* stable while f_valid & ~f_ready.
- Pointers: log2(DEPTH)-bit wrap naturally (DEPTH-1 → 0).
- count updates:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Simultaneous push and pop:
  - Legal whenever not full (f_ready = 0 when full).
  - When full, pop frees a slot only for the next cycle.
  - When count == 1, push+pop leaves count = 1 with the new packet at head after the edge.
- Empty: d_ready is ignored; no pointer movement.
- Full: f_valid is ignored; no overwrite.
- flush:
  - Highest priority. At the edge it forces rd_ptr = wr_ptr = count = 0.
  - Any same-cycle push or pop is discarded.
  - d_valid = 0 from the next cycle; f_ready = 1 from the next cycle.
  - The fetch side sees f_ready high during the flush cycle but the packet is dropped (fetch re-issues from the redirect PC).
- Reset mid-operation: immediate return to reset state regardless of flush/push/pop. Queue contents are lost.
- No x-propagation:
  - d_* are zero when empty.
  - count never exceeds DEPTH or underflows (asserted in RTL).

Decomposition:
- Package if_id_pkg:
  - typedef fetch_pkt_t, a packed struct {pc, pc4, inst} parametrised via package localparams XLEN = 64, ILEN = 32.
  - Function clog2_cnt for the count width.
- Sub-module fetch_pkt_fifo: generic FWFT storage with pointers, count and flags (push/pop/flush in; head data out).
- if_id_queue wraps it with the handshake, output zeroing and almost_full compare.

Test Plan:
- Reset: hold reset low 3 cycles while f_valid = 1 → d_valid = 0, count = 0, f_ready = 1, d_pc = 0; release, push pc = 0x1000 inst = 0x00000013 → next cycle d_valid = 1, d_pc = 0x1000, d_pc4 = 0x1004, count = 1.
- Fill/backpressure: DEPTH = 4, d_ready = 0, push pc 0x0,0x4,0x8,0xC:
  - almost_full asserts at count = 3; full and f_ready = 0 at count = 4.
  - A fifth packet 0x10 is held by fetch and is not lost.
  - Raise d_ready → drains 0x0,0x4,0x8,0xC,0x10 in order.
- Concurrent push/pop: stream 12 packets with d_ready = 1 every cycle → count stays 1, d_pc advances by 4 each cycle, wrap after 4 entries is correct.
- Flush: count = 3, assert flush with f_valid = 1 and d_ready = 1 → after the edge count = 0, d_valid = 0, empty = 1; the next push of pc = 0x2000 appears at head.
- Async reset mid-stream: count = 2, drop reset between edges → d_valid and count clear immediately (before the next clk edge).
- Random: 10k cycles of random f_valid/d_ready/flush against a scoreboard queue → in-order, no loss or duplication; d_* are stable while stalled.
